// File: rtl/seq_add32.sv
// Multi-cycle adder/subtractor: walks one 4-bit carry-lookahead slice across
// the operands LSB nibble first, carrying between nibbles through a register.

module cla4 (
  input  logic [3:0] din1,
  input  logic [3:0] din2,
  input  logic       carry_in,
  output logic [3:0] dout,
  output logic       carry_out,
  output logic       overflow
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = din1 & din2;
    p    = din1 ^ din2;
    c[0] = carry_in;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    dout      = p ^ c[3:0];
    carry_out = c[4];
    overflow  = c[3] ^ c[4];
  end
endmodule

module seq_add32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);
  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic             carry_q;

  logic [3:0] s_dout;
  logic       s_carry;
  logic       s_ovf;

  cla4 u_slice (
    .din1      (opa[3:0]),
    .din2      (opb[3:0]),
    .carry_in  (carry_q),
    .dout      (s_dout),
    .carry_out (s_carry),
    .overflow  (s_ovf)
  );

  // Subtraction is a + ~b + 1, with the +1 injected as the initial carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      carry_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            opa     <= a;
            opb     <= sub ? ~b : b;
            carry_q <= sub;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          opa     <= {4'b0000, opa[WIDTH-1:4]};
          opb     <= {4'b0000, opb[WIDTH-1:4]};
          acc     <= {s_dout, acc[WIDTH-1:4]};
          carry_q <= s_carry;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            result    <= {s_dout, acc[WIDTH-1:4]};
            carry_out <= s_carry;
            overflow  <= s_ovf;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
